// File: rtl/vga_box_renderer.sv
// Colour stage behind the VGA timing generator: draws a bouncing box over a background and
// re-times the syncs so colour and sync stay aligned. Define VGA_BOX_BORDER_EN for a white 1-px frame border.
module vga_box_renderer #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BOX_SIZE     = 32,
    parameter int          STEP         = 2,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] BG_COLOR     = 12'h008,
    parameter logic [11:0] BOX_COLOR    = 12'hF80,
    parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
    input  logic       VGA_clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    input  logic       displayArea,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_hSync,
    output logic       VGA_vSync,
    output logic       frameTick,
    output logic [9:0] boxX,
    output logic [9:0] boxY
);

    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  X_START = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  Y_START = 10'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [10:0] SIZE11  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [9:0]  STEP10  = 10'(STEP);
    localparam int          CW      = $clog2(FLASH_FRAMES) + 1;
    localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {PAUSE, MOVE, FLASH} state_t;

    state_t        state, state_n;
    logic          dir_x, dir_y, dir_x_n, dir_y_n;   // 1 = right / down
    logic [9:0]    box_x_n, box_y_n;
    logic [CW-1:0] flash_cnt, flash_cnt_n;

    logic in_box_x, in_box_y;
    logic s1_in_box, s1_da, s1_hsync, s1_vsync;
    logic [11:0] pix_color, rgb;
    logic vsync_prev;

    // Stage 1: box hit test, compared in 11 bits so the far edge never wraps.
    assign in_box_x = ({1'b0, xCount} >= {1'b0, boxX}) && ({1'b0, xCount} < ({1'b0, boxX} + SIZE11));
    assign in_box_y = ({1'b0, yCount} >= {1'b0, boxY}) && ({1'b0, yCount} < ({1'b0, boxY} + SIZE11));

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_box <= 1'b0;
            s1_da     <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
        end else begin
            s1_in_box <= in_box_x && in_box_y;
            s1_da     <= displayArea;
            s1_hsync  <= hSyncIn;
            s1_vsync  <= vSyncIn;
        end
    end

`ifdef VGA_BOX_BORDER_EN
    logic s1_border;

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) s1_border <= 1'b0;
        else        s1_border <= (xCount == 10'd0) || (xCount == 10'(H_ACTIVE - 1)) ||
                                 (yCount == 10'd0) || (yCount == 10'(V_ACTIVE - 1));
    end
`endif

    // Stage 2: colour mux; box wins over border, border over background.
    always_comb begin
        pix_color = BG_COLOR;
        if (!s1_da)         pix_color = 12'h000;
        else if (s1_in_box) pix_color = (state == FLASH) ? FLASH_COLOR : BOX_COLOR;
`ifdef VGA_BOX_BORDER_EN
        else if (s1_border) pix_color = 12'hFFF;
`endif
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= 12'h000;
            VGA_hSync <= 1'b1;
            VGA_vSync <= 1'b1;
        end else begin
            rgb       <= pix_color;
            VGA_hSync <= s1_hsync;
            VGA_vSync <= s1_vsync;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb;

    // Frame tick fires the cycle after vSync falls, i.e. inside vertical blanking.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev <= 1'b1;
            frameTick  <= 1'b0;
        end else begin
            vsync_prev <= vSyncIn;
            frameTick  <= vsync_prev & ~vSyncIn;
        end
    end

    logic [9:0] mv_x, mv_y;
    logic       mv_dir_x, mv_dir_y, hit_x, hit_y, hit;

    always_comb begin
        mv_x     = boxX;
        mv_dir_x = dir_x;
        hit_x    = 1'b0;
        if (dir_x) begin
            if (({1'b0, boxX} + STEP11) >= {1'b0, X_MAX}) begin
                mv_x = X_MAX; mv_dir_x = 1'b0; hit_x = 1'b1;
            end else begin
                mv_x = boxX + STEP10;
            end
        end else begin
            if ({1'b0, boxX} <= STEP11) begin
                mv_x = 10'd0; mv_dir_x = 1'b1; hit_x = 1'b1;
            end else begin
                mv_x = boxX - STEP10;
            end
        end
    end

    always_comb begin
        mv_y     = boxY;
        mv_dir_y = dir_y;
        hit_y    = 1'b0;
        if (dir_y) begin
            if (({1'b0, boxY} + STEP11) >= {1'b0, Y_MAX}) begin
                mv_y = Y_MAX; mv_dir_y = 1'b0; hit_y = 1'b1;
            end else begin
                mv_y = boxY + STEP10;
            end
        end else begin
            if ({1'b0, boxY} <= STEP11) begin
                mv_y = 10'd0; mv_dir_y = 1'b1; hit_y = 1'b1;
            end else begin
                mv_y = boxY - STEP10;
            end
        end
    end

    // A corner bounce flips both axes but is still a single flash event.
    assign hit = hit_x | hit_y;

    // Every state moves the box on a tick exactly when run is high.
    always_comb begin
        state_n     = state;
        box_x_n     = boxX;
        box_y_n     = boxY;
        dir_x_n     = dir_x;
        dir_y_n     = dir_y;
        flash_cnt_n = flash_cnt;
        if (frameTick) begin
            if (run) begin
                box_x_n = mv_x;
                box_y_n = mv_y;
                dir_x_n = mv_dir_x;
                dir_y_n = mv_dir_y;
            end
            unique case (state)
                PAUSE: begin
                    if (run) state_n = MOVE;
                end
                MOVE: begin
                    if (!run) begin
                        state_n = PAUSE;
                    end else if (hit) begin
                        state_n     = FLASH;
                        flash_cnt_n = FLASH_LOAD;
                    end
                end
                FLASH: begin
                    if (!run) begin
                        state_n     = PAUSE;
                        flash_cnt_n = '0;
                    end else if (hit) begin
                        flash_cnt_n = FLASH_LOAD;
                    end else if (flash_cnt == '0) begin
                        state_n = MOVE;
                    end else begin
                        flash_cnt_n = flash_cnt - 1'b1;
                    end
                end
                default: begin
                    state_n     = PAUSE;
                    flash_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PAUSE;
            boxX      <= X_START;
            boxY      <= Y_START;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            flash_cnt <= '0;
        end else begin
            state     <= state_n;
            boxX      <= box_x_n;
            boxY      <= box_y_n;
            dir_x     <= dir_x_n;
            dir_y     <= dir_y_n;
            flash_cnt <= flash_cnt_n;
        end
    end

endmodule
